// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding unit.
// The optional HAZ_PERF_CNT_EN feature does not change anything in this package.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LU_STALL,
        MC_WAIT
    } hz_state_e;

    localparam int unsigned REG_ZERO = '0;

    // Width of a forward select that encodes "regfile" plus n stages.
    function automatic int fsel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_match.sv
// fwd_match: nearest-stage priority encoder for one source operand.
// Output 0 selects the register file, k selects forwarding stage k.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5
) (
    input  logic [REG_AW-1:0]            i_rs,
    input  logic [NUM_STAGES*REG_AW-1:0] i_stage_rd,
    input  logic [NUM_STAGES-1:0]        i_stage_regwrite,
    output logic [fsel_w(NUM_STAGES)-1:0] o_sel
);

    localparam int FSW = fsel_w(NUM_STAGES);
    localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

    // Scan farthest to nearest so the nearest matching stage overwrites the rest.
    always_comb begin
        o_sel = '0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (i_stage_regwrite[k-1] &&
                (i_stage_rd[(k-1)*REG_AW +: REG_AW] == i_rs) &&
                (i_stage_rd[(k-1)*REG_AW +: REG_AW] != RZ)) begin
                o_sel = FSW'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forward selects plus load-use and multi-cycle-op stall control.
// Define HAZ_PERF_CNT_EN to add saturating stall performance counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int NUM_STAGES   = 2,
    parameter int REG_AW       = 5,
    parameter int LU_STALL_CYC = 1,
    parameter int MC_TIMEOUT   = 64,
    localparam int FSW         = fsel_w(NUM_STAGES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]     ex_rs,
    input  logic [NUM_STAGES*REG_AW-1:0]  stage_rd,
    input  logic [NUM_STAGES-1:0]         stage_regwrite,
    input  logic [NUM_SRC*REG_AW-1:0]     id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_AW-1:0]             idex_rd,
    input  logic                          idex_memread,
    input  logic                          mc_start,
    input  logic                          mc_done,
    output logic [NUM_SRC*FSW-1:0]        fwd_sel,
    output logic                          stall_if,
    output logic                          stall_id,
    output logic                          stall_ex,
    output logic                          flush_ex,
    output logic                          mc_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                   lu_stall_cnt,
    output logic [31:0]                   mc_stall_cnt
`endif
);

    localparam int CNT_W = (MC_TIMEOUT > 8) ? $clog2(MC_TIMEOUT) : 3;
    localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

    hz_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu_hit;
    logic             w_timeout;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW)
        ) u_match (
            .i_rs             (ex_rs[i*REG_AW +: REG_AW]),
            .i_stage_rd       (stage_rd),
            .i_stage_regwrite (stage_regwrite),
            .o_sel            (fwd_sel[i*FSW +: FSW])
        );
    end

    always_comb begin
        w_lu_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == idex_rd)) begin
                w_lu_hit = 1'b1;
            end
        end
        w_lu_hit = w_lu_hit && idex_memread && (idex_rd != RZ);
    end

    // mc_done takes precedence, so a completion on the last allowed cycle is not reported as a timeout.
    assign w_timeout = (MC_TIMEOUT != 0) && (r_state == MC_WAIT) && !mc_done &&
                       (r_cnt == CNT_W'(MC_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mc_start) begin
                        r_cnt   <= '0;
                        r_state <= MC_WAIT;
                    end else if (w_lu_hit && (LU_STALL_CYC > 1)) begin
                        r_cnt   <= CNT_W'(LU_STALL_CYC - 1);
                        r_state <= LU_STALL;
                    end
                end
                LU_STALL: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= IDLE;
                    end
                end
                MC_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mc_done || w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Controls act in the same cycle as the triggering inputs; rst_n gates them so a reset drops stalls at once.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        flush_ex   = 1'b0;
        mc_timeout = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (mc_start) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                    end else if (w_lu_hit) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                LU_STALL: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                end
                MC_WAIT: begin
                    mc_timeout = w_timeout;
                    if (!mc_done && !w_timeout) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_mc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lu_cnt <= '0;
            r_mc_cnt <= '0;
        end else begin
            if (flush_ex && (r_lu_cnt != '1)) begin
                r_lu_cnt <= r_lu_cnt + 32'd1;
            end
            if (stall_ex && (r_mc_cnt != '1)) begin
                r_mc_cnt <= r_mc_cnt + 32'd1;
            end
        end
    end

    assign lu_stall_cnt = r_lu_cnt;
    assign mc_stall_cnt = r_mc_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: one instance with LU_STALL_CYC=1/MC_TIMEOUT=8 and one with 3/0.
// Perf counter checks are included when HAZ_PERF_CNT_EN is defined.
module tb_hazard_forward_unit;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LUS  = 5'b11010;
    localparam logic [4:0] MCS  = 5'b11100;
    localparam logic [4:0] TOUT = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] ex_rs;
    logic [9:0] stage_rd;
    logic [1:0] stage_regwrite;
    logic [9:0] id_rs;
    logic [1:0] id_rs_used;
    logic [4:0] idex_rd;
    logic       idex_memread;
    logic       mc_start;
    logic       mc_done;

    logic [3:0] fwdSel1, fwdSel3;
    logic       stallIf1, stallId1, stallEx1, flushEx1, mcTimeout1;
    logic       stallIf3, stallId3, stallEx3, flushEx3, mcTimeout3;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] luCnt1, mcCnt1, luCnt3, mcCnt3;
`endif

    int nChecks = 0;
    int nFail   = 0;

    wire [4:0] ctl1 = {stallIf1, stallId1, stallEx1, flushEx1, mcTimeout1};
    wire [4:0] ctl3 = {stallIf3, stallId3, stallEx3, flushEx3, mcTimeout3};

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .NUM_SRC(2), .NUM_STAGES(2), .REG_AW(5), .LU_STALL_CYC(1), .MC_TIMEOUT(8)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .stage_rd(stage_rd),
        .stage_regwrite(stage_regwrite), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .mc_start(mc_start),
        .mc_done(mc_done), .fwd_sel(fwdSel1), .stall_if(stallIf1), .stall_id(stallId1),
        .stall_ex(stallEx1), .flush_ex(flushEx1), .mc_timeout(mcTimeout1)
`ifdef HAZ_PERF_CNT_EN
        , .lu_stall_cnt(luCnt1), .mc_stall_cnt(mcCnt1)
`endif
    );

    hazard_forward_unit #(
        .NUM_SRC(2), .NUM_STAGES(2), .REG_AW(5), .LU_STALL_CYC(3), .MC_TIMEOUT(0)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .stage_rd(stage_rd),
        .stage_regwrite(stage_regwrite), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .idex_rd(idex_rd), .idex_memread(idex_memread), .mc_start(mc_start),
        .mc_done(mc_done), .fwd_sel(fwdSel3), .stall_if(stallIf3), .stall_id(stallId3),
        .stall_ex(stallEx3), .flush_ex(flushEx3), .mc_timeout(mcTimeout3)
`ifdef HAZ_PERF_CNT_EN
        , .lu_stall_cnt(luCnt3), .mc_stall_cnt(mcCnt3)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Control vector order: {stall_if, stall_id, stall_ex, flush_ex, mc_timeout}.
    task automatic checkCtl(input string tag, input logic [4:0] exp1, input logic [4:0] exp3);
        checkOutput({tag, "_lu1"}, 32'(ctl1), 32'(exp1));
        checkOutput({tag, "_lu3"}, 32'(ctl3), 32'(exp3));
    endtask

    // Drives the hazard-side inputs for one cycle, settling 2 time units after the rising edge.
    task automatic applyStimulus(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs0, input logic [1:0] used,
                                 input logic st, input logic dn);
        @(posedge clk);
        #1;
        idex_memread = ld;
        idex_rd      = rd;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
        mc_start     = st;
        mc_done      = dn;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        ex_rs          = '0;
        stage_rd       = '0;
        stage_regwrite = '0;
        id_rs          = '0;
        id_rs_used     = '0;
        idex_rd        = '0;
        idex_memread   = 1'b0;
        mc_start       = 1'b0;
        mc_done        = 1'b0;

        // Reset: controls stay low even with mc_start driven
        #1;
        mc_start = 1'b1;
        #1;
        checkCtl("reset_ctl", NONE, NONE);
`ifdef HAZ_PERF_CNT_EN
        checkOutput("reset_lucnt", luCnt1, 32'd0);
        checkOutput("reset_mccnt", mcCnt1, 32'd0);
`endif
        @(posedge clk);
        #1;
        mc_start = 1'b0;
        rst_n    = 1'b1;
        #1;
        checkCtl("idle_after_reset", NONE, NONE);

        // Forwarding priority (fwd_sel = {sel rs1, sel rs0})
        ex_rs          = {5'd5, 5'd7};
        stage_rd       = {5'd7, 5'd5};
        stage_regwrite = 2'b11;
        #1;
        checkOutput("fwd_split", 32'(fwdSel1), 32'(4'b0110));
        stage_rd = {5'd0, 5'd0};
        #1;
        checkOutput("fwd_x0", 32'(fwdSel1), 32'(4'b0000));
        stage_rd = {5'd5, 5'd5};
        #1;
        checkOutput("fwd_nearest", 32'(fwdSel1), 32'(4'b0100));
        stage_regwrite = 2'b10;
        #1;
        checkOutput("fwd_far_only", 32'(fwdSel3), 32'(4'b1000));
        stage_regwrite = 2'b00;
        #1;
        checkOutput("fwd_no_write", 32'(fwdSel1), 32'(4'b0000));

        // Load-use: 1 bubble on u_dut1, 3 bubbles on u_dut3
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 2'b11, 1'b0, 1'b0);
        checkCtl("lu_c0", LUS, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("lu_c1", NONE, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("lu_c2", NONE, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("lu_c3", NONE, NONE);

        // No hazard: operand unused, or load targets x0; mc_done alone is ignored
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 2'b01, 1'b0, 1'b0);
        checkCtl("lu_unused", NONE, NONE);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0, 1'b0);
        checkCtl("lu_rd_x0", NONE, NONE);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        checkCtl("done_in_idle", NONE, NONE);

        // Multi-cycle op: 6 stalled cycles, released in the mc_done cycle
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
        checkCtl("mc_c0", MCS, MCS);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
            checkCtl($sformatf("mc_c%0d", c), MCS, MCS);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        checkCtl("mc_done", NONE, NONE);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("mc_after", NONE, NONE);

        // mc_start together with a load-use hit: multi-cycle wins, no flush
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 2'b10, 1'b1, 1'b0);
        checkCtl("both_c0", MCS, MCS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("both_c1", MCS, MCS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        checkCtl("both_done", NONE, NONE);

        // mc_start during LU_STALL is ignored by u_dut3, taken by idle u_dut1
        applyStimulus(1'b1, 5'd4, 5'd0, 5'd4, 2'b01, 1'b0, 1'b0);
        checkCtl("luign_c0", LUS, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
        checkCtl("luign_c1", MCS, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        checkCtl("luign_c2", NONE, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("luign_c3", NONE, NONE);

        // Timeout: u_dut1 releases on the 8th MC_WAIT cycle, u_dut3 waits for mc_done
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
        checkCtl("to_c0", MCS, MCS);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
            checkCtl($sformatf("to_c%0d", c), MCS, MCS);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("to_c8", TOUT, MCS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        checkCtl("to_c9", NONE, NONE);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("to_c10", NONE, NONE);

        // Reset in the middle of MC_WAIT drops the stalls without a clock edge
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
        checkCtl("rst_c0", MCS, MCS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("rst_c1", MCS, MCS);
        #3;
        rst_n = 1'b0;
        #1;
        checkCtl("rst_async", NONE, NONE);
`ifdef HAZ_PERF_CNT_EN
        checkOutput("rst_lucnt", luCnt3, 32'd0);
        checkOutput("rst_mccnt", mcCnt1, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 2'b10, 1'b0, 1'b0);
        checkCtl("rst_idle_lu", LUS, LUS);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        checkCtl("rst_idle_c1", NONE, LUS);
`ifdef HAZ_PERF_CNT_EN
        checkOutput("perf_lucnt", luCnt1, 32'd1);
        checkOutput("perf_mccnt", mcCnt1, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
